sap1_datapath: RTL and testbench
================================

Name: sap1_datapath

Overview:
- SAP-1 datapath: the consumer end of the 12-bit control word produced by the SAP-1 controller.
- Holds PC, MAR, 16x8 RAM, IR, A, B, the add/subtract ALU and the OUT register, all joined by a single 8-bit bus.
- Executes each control word on the rising clock edge; the controller changes the word on the falling edge.
- Returns the opcode nibble to the controller and exposes the output register and debug state.

Parameters:
- WIDTH, 8, data/bus width in bits.
- ADDR_W, 4, address width; PC, MAR and IR operand nibble are this wide; RAM depth is 2^ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous active-low reset; acts on posedge CLK while 0.
- CW  in  12  control word, bit 11..0 = CE, CO, MI, RO, II, IO, AI, AO, SU, EO, BI, OI.
- HLT  in  1  halt; when 1, no register updates (bus and ALU outputs are still driven combinationally).
- PROG_WE  in  1  program-load write enable into RAM.
- PROG_ADDR  in  ADDR_W  program-load address.
- PROG_DATA  in  WIDTH  program-load data.
- OPCODE  out  4  IR[7:4], to controller.
- OUT_REG  out  WIDTH  output register.
- BUS  out  WIDTH  current bus value (debug).
- CF  out  1  carry flag.
- ZF  out  1  zero flag.
- BUS_ERR  out  1  sticky bus-contention flag.

Behaviour:
- Reset, while RST=0 at posedge: PC, MAR, IR, A, B, OUT_REG, CF, ZF, BUS_ERR all 0.
  - RAM contents are not cleared.
  - CW and PROG_WE are ignored in that cycle.
- Bus drivers (combinational):
  - CO: {0, PC}.
  - RO: RAM[MAR].
  - IO: {0, IR[3:0]}.
  - AO: A.
  - EO: ALU result.
- Bus value with no driver active: 8'h00.
- Bus value with two or more drivers active: 8'h00, and BUS_ERR sets at the next posedge (no HLT), sticky until reset.
- ALU (combinational):
  - SU=0: A+B.
  - SU=1: A+~B+1.
  - Result truncated to WIDTH.
  - Carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - On subtract, carry=1 means no borrow.
- Loads at posedge when RST=1 and HLT=0, all using the pre-edge bus value:
  - MI: MAR <= BUS[3:0].
  - II: IR <= BUS.
  - AI: A <= BUS.
  - BI: B <= BUS.
  - OI: OUT_REG <= BUS.
  - Multiple loads in one cycle are legal.
- CE: PC <= PC+1 mod 16; 15 wraps to 0.
  - CE together with CO: the bus carries the old PC; increment still occurs.
- Flags: when EO=1 and AI=1 at an active edge, CF <= ALU carry and ZF <= (ALU result == 0). Otherwise flags hold.
- RAM write port:
  - PROG_WE=1 at posedge (RST=1) writes PROG_DATA to RAM[PROG_ADDR].
  - Honoured regardless of HLT.
  - No bus path writes RAM.
- RAM read is asynchronous.
  - Read of the address being written in the same cycle returns the old data; new data is visible after the edge.
- HLT=1: every register, including BUS_ERR and flags, holds.
- RST has priority over HLT and PROG_WE.
- Reset mid-instruction: all registers clear in that cycle; the controller restarts fetch independently.
- Latency: a value placed on the bus in cycle n is visible in the destination register output in cycle n+1.

Decomposition:
- Shared package sap1_pkg holds:
  - CW bit-index constants (CE_B=11 ... OI_B=0).
  - CW_W=12.
  - Opcode constants: LDA=0, ADD=1, SUB=2, OUT=14, HLT=15.
- The controller imports the same package.
- One sub-module: sap1_alu (combinational add/sub, result, carry, zero).
- RAM stays inline as a register array.

Test Plan:
- Reset clears state: load RAM[0]=8'h1F, hold RST=0 for 2 cycles -> all registers and flags 0, RAM[0] still 8'h1F.
- Fetch: PC=0, RAM[0]=8'h1E; CW=CO|MI, then RO|II|CE -> MAR=0, IR=8'h1E, OPCODE=1, PC=1.
- Add: A=8'hF0, B=8'h20, CW=EO|AI -> A=8'h10, CF=1, ZF=0; then OI with AO -> OUT_REG=8'h10.
- Subtract to zero: A=8'h05, B=8'h05, CW=SU|EO|AI -> A=8'h00, CF=1, ZF=1.
- PC wrap and halt: PC=15, CE -> PC=0; with HLT=1, CE|AI and CO -> no change, PC stays 0.
- Contention: CW=AO|RO|BI -> BUS=8'h00, B=8'h00, BUS_ERR=1 next cycle and it stays 1 until RST=0.

Source files
------------

// File: rtl/sap1_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap1_pkg : control-word bit positions and opcodes shared by the    |
// |            SAP-1 controller and datapath.          Revision: 1.0   |
// +--------------------------------------------------------------------+
package sap1_pkg;
  localparam int CW_W = 12;

  localparam int CE_B = 11;
  localparam int CO_B = 10;
  localparam int MI_B = 9;
  localparam int RO_B = 8;
  localparam int II_B = 7;
  localparam int IO_B = 6;
  localparam int AI_B = 5;
  localparam int AO_B = 4;
  localparam int SU_B = 3;
  localparam int EO_B = 2;
  localparam int BI_B = 1;
  localparam int OI_B = 0;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;
endpackage
`default_nettype wire

// File: rtl/sap1_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap1_alu : combinational add / two's-complement subtract with      |
// |            carry-out and zero detect.              Revision: 1.0   |
// +--------------------------------------------------------------------+
module sap1_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_su,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero
);
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;

  // Subtract as A + ~B + 1, so carry=1 means no borrow.
  assign w_b_op   = i_su ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, i_su};
  assign o_result = w_sum[WIDTH-1:0];
  assign o_carry  = w_sum[WIDTH];
  assign o_zero   = (w_sum[WIDTH-1:0] == '0);
endmodule
`default_nettype wire

// File: rtl/sap1_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap1_datapath : SAP-1 registers, RAM, ALU and shared 8-bit bus,    |
// |                 driven by the controller's control word. Rev: 1.0  |
// +--------------------------------------------------------------------+
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CW_W-1:0]   CW,
  input  logic              HLT,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [WIDTH-1:0]  PROG_DATA,
  output logic [3:0]        OPCODE,
  output logic [WIDTH-1:0]  OUT_REG,
  output logic [WIDTH-1:0]  BUS,
  output logic              CF,
  output logic              ZF,
  output logic              BUS_ERR
);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [WIDTH-1:0]  r_ir;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_out;
  logic              r_cf;
  logic              r_zf;
  logic              r_bus_err;
  logic [WIDTH-1:0]  r_ram [2**ADDR_W];

  logic [WIDTH-1:0]  w_bus;
  logic [WIDTH-1:0]  w_pc_ext;
  logic [WIDTH-1:0]  w_ir_ext;
  logic [WIDTH-1:0]  w_ram_rd;
  logic [WIDTH-1:0]  w_alu;
  logic              w_carry;
  logic              w_zero;
  logic [2:0]        w_n_drv;

  sap1_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_su     (CW[SU_B]),
    .o_result (w_alu),
    .o_carry  (w_carry),
    .o_zero   (w_zero)
  );

  assign w_pc_ext = {{(WIDTH-ADDR_W){1'b0}}, r_pc};
  assign w_ir_ext = {{(WIDTH-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
  assign w_ram_rd = r_ram[r_mar];
  assign w_n_drv  = {2'b0, CW[CO_B]} + {2'b0, CW[RO_B]} + {2'b0, CW[IO_B]}
                  + {2'b0, CW[AO_B]} + {2'b0, CW[EO_B]};

  // Contention or an idle bus both read as zero.
  always_comb begin
    w_bus = '0;
    if (w_n_drv == 3'd1) begin
      w_bus = ({WIDTH{CW[CO_B]}} & w_pc_ext)
            | ({WIDTH{CW[RO_B]}} & w_ram_rd)
            | ({WIDTH{CW[IO_B]}} & w_ir_ext)
            | ({WIDTH{CW[AO_B]}} & r_a)
            | ({WIDTH{CW[EO_B]}} & w_alu);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_pc      <= '0;
      r_mar     <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_out     <= '0;
      r_cf      <= 1'b0;
      r_zf      <= 1'b0;
      r_bus_err <= 1'b0;
    end else if (!HLT) begin
      if (CW[CE_B]) r_pc  <= r_pc + ADDR_W'(1);
      if (CW[MI_B]) r_mar <= w_bus[ADDR_W-1:0];
      if (CW[II_B]) r_ir  <= w_bus;
      if (CW[AI_B]) r_a   <= w_bus;
      if (CW[BI_B]) r_b   <= w_bus;
      if (CW[OI_B]) r_out <= w_bus;
      if (CW[EO_B] && CW[AI_B]) begin
        r_cf <= w_carry;
        r_zf <= w_zero;
      end
      if (w_n_drv > 3'd1) r_bus_err <= 1'b1;
    end
  end

  // Program loading bypasses HLT; RAM is never cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST && PROG_WE) r_ram[PROG_ADDR] <= PROG_DATA;
  end

  assign OPCODE  = r_ir[WIDTH-1 -: 4];
  assign OUT_REG = r_out;
  assign BUS     = w_bus;
  assign CF      = r_cf;
  assign ZF      = r_zf;
  assign BUS_ERR = r_bus_err;
endmodule
`default_nettype wire

// File: tb/tb_sap1_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sap1_datapath : vector table plus hand sequences, outputs       |
// |                    scoreboarded through a queue.   Revision: 1.0   |
// +--------------------------------------------------------------------+
module tb_sap1_datapath;
  localparam logic [11:0] C_CE = 12'h800, C_CO = 12'h400, C_MI = 12'h200,
                          C_RO = 12'h100, C_II = 12'h080, C_IO = 12'h040,
                          C_AI = 12'h020, C_AO = 12'h010, C_SU = 12'h008,
                          C_EO = 12'h004, C_BI = 12'h002, C_OI = 12'h001;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] out;
    logic       cf;
    logic       zf;
    logic       err;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       hlt;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [11:0] cw;
    logic [7:0] bus;
    obs_t       exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [11:0] CW = '0;
  logic        HLT = 1'b0;
  logic        PROG_WE = 1'b0;
  logic [3:0]  PROG_ADDR = '0;
  logic [7:0]  PROG_DATA = '0;
  logic [3:0]  OPCODE;
  logic [7:0]  OUT_REG;
  logic [7:0]  BUS;
  logic        CF;
  logic        ZF;
  logic        BUS_ERR;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t sb_q[$];
  vec_t vt[25];

  sap1_datapath #(.WIDTH(8), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST), .CW(CW), .HLT(HLT), .PROG_WE(PROG_WE),
    .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .OPCODE(OPCODE),
    .OUT_REG(OUT_REG), .BUS(BUS), .CF(CF), .ZF(ZF), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst, input logic hlt, input logic we,
                              input logic [3:0] wa, input logic [7:0] wd,
                              input logic [11:0] cw, input logic [7:0] bus,
                              input logic [3:0] op, input logic [7:0] out,
                              input logic cf, input logic zf, input logic err);
    vec_t v;
    v.rst = rst; v.hlt = hlt; v.we = we; v.waddr = wa; v.wdata = wd;
    v.cw = cw; v.bus = bus;
    v.exp = '{op: op, out: out, cf: cf, zf: zf, err: err};
    return v;
  endfunction

  // Drive at negedge, check the bus mid-cycle, check registered outputs after posedge.
  task automatic step(input vec_t v, input string tag);
    obs_t got;
    obs_t want;
    @(negedge CLK);
    RST = v.rst; HLT = v.hlt; CW = v.cw;
    PROG_WE = v.we; PROG_ADDR = v.waddr; PROG_DATA = v.wdata;
    #1;
    n_checks++;
    if (BUS !== v.bus) begin
      n_errors++;
      $display("FAIL %s bus: got %h expected %h", tag, BUS, v.bus);
    end
    sb_q.push_back(v.exp);
    @(posedge CLK);
    #1;
    want = sb_q.pop_front();
    got  = '{op: OPCODE, out: OUT_REG, cf: CF, zf: ZF, err: BUS_ERR};
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s outputs: got op=%h out=%h cf=%b zf=%b err=%b expected op=%h out=%h cf=%b zf=%b err=%b",
               tag, got.op, got.out, got.cf, got.zf, got.err,
               want.op, want.out, want.cf, want.zf, want.err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, RAM retention, fetch, add, subtract, flag hold, same-cycle RAM write/read.
    vt[0]  = mk(0,0,0,4'h0,8'h00, 12'h000,        8'h00, 4'h0,8'h00,0,0,0);
    vt[1]  = mk(1,0,1,4'h0,8'h1F, 12'h000,        8'h00, 4'h0,8'h00,0,0,0);
    vt[2]  = mk(0,0,1,4'h0,8'h55, C_CE|C_AI,      8'h00, 4'h0,8'h00,0,0,0);
    vt[3]  = mk(0,0,0,4'h0,8'h00, 12'h000,        8'h00, 4'h0,8'h00,0,0,0);
    vt[4]  = mk(1,0,0,4'h0,8'h00, C_RO|C_AI,      8'h1F, 4'h0,8'h00,0,0,0);
    vt[5]  = mk(1,0,0,4'h0,8'h00, C_AO|C_OI,      8'h1F, 4'h0,8'h1F,0,0,0);
    vt[6]  = mk(1,0,1,4'h0,8'h1E, C_CO|C_MI,      8'h00, 4'h0,8'h1F,0,0,0);
    vt[7]  = mk(1,0,1,4'h1,8'hF0, C_RO|C_II|C_CE, 8'h1E, 4'h1,8'h1F,0,0,0);
    vt[8]  = mk(1,0,1,4'h2,8'h20, C_CO|C_MI,      8'h01, 4'h1,8'h1F,0,0,0);
    vt[9]  = mk(1,0,1,4'h3,8'h05, C_RO|C_AI,      8'hF0, 4'h1,8'h1F,0,0,0);
    vt[10] = mk(1,0,0,4'h0,8'h00, C_CO|C_MI|C_CE, 8'h01, 4'h1,8'h1F,0,0,0);
    vt[11] = mk(1,0,0,4'h0,8'h00, C_CO|C_MI,      8'h02, 4'h1,8'h1F,0,0,0);
    vt[12] = mk(1,0,0,4'h0,8'h00, C_RO|C_BI,      8'h20, 4'h1,8'h1F,0,0,0);
    vt[13] = mk(1,0,0,4'h0,8'h00, C_EO|C_AI,      8'h10, 4'h1,8'h1F,1,0,0);
    vt[14] = mk(1,0,0,4'h0,8'h00, C_AO|C_OI,      8'h10, 4'h1,8'h10,1,0,0);
    vt[15] = mk(1,0,0,4'h0,8'h00, C_CO|C_MI|C_CE, 8'h02, 4'h1,8'h10,1,0,0);
    vt[16] = mk(1,0,0,4'h0,8'h00, C_CO|C_MI,      8'h03, 4'h1,8'h10,1,0,0);
    vt[17] = mk(1,0,0,4'h0,8'h00, C_RO|C_AI|C_BI, 8'h05, 4'h1,8'h10,1,0,0);
    vt[18] = mk(1,0,0,4'h0,8'h00, C_SU|C_EO|C_AI, 8'h00, 4'h1,8'h10,1,1,0);
    vt[19] = mk(1,0,0,4'h0,8'h00, C_EO|C_OI,      8'h05, 4'h1,8'h05,1,1,0);
    vt[20] = mk(1,0,1,4'h3,8'h77, C_RO|C_AI,      8'h05, 4'h1,8'h05,1,1,0);
    vt[21] = mk(1,0,0,4'h0,8'h00, C_RO|C_OI,      8'h77, 4'h1,8'h77,1,1,0);
    vt[22] = mk(1,0,0,4'h0,8'h00, C_RO|C_BI,      8'h77, 4'h1,8'h77,1,1,0);
    vt[23] = mk(1,0,0,4'h0,8'h00, C_SU|C_EO|C_AI, 8'h8E, 4'h1,8'h77,0,0,0);
    vt[24] = mk(1,0,0,4'h0,8'h00, C_IO|C_OI,      8'h0E, 4'h1,8'h0E,0,0,0);

    for (int i = 0; i < 25; i++) step(vt[i], $sformatf("vec%0d", i));

    // PC from 3 up to 15, then wrap to 0.
    for (int i = 0; i < 12; i++)
      step(mk(1,0,0,4'h0,8'h00, C_CE, 8'h00, 4'h1,8'h0E,0,0,0), "pc_count");
    step(mk(1,0,0,4'h0,8'h00, C_CO, 8'h0F, 4'h1,8'h0E,0,0,0), "pc_at_15");
    step(mk(1,0,0,4'h0,8'h00, C_CE, 8'h00, 4'h1,8'h0E,0,0,0), "pc_wrap");
    step(mk(1,0,0,4'h0,8'h00, C_CO, 8'h00, 4'h1,8'h0E,0,0,0), "pc_is_0");

    // Halt freezes registers but not the program-load port.
    step(mk(1,1,1,4'h5,8'hAA, C_CE|C_AI|C_CO, 8'h00, 4'h1,8'h0E,0,0,0), "hlt_ce_ai");
    step(mk(1,1,0,4'h0,8'h00, C_EO|C_AI|C_OI, 8'h05, 4'h1,8'h0E,0,0,0), "hlt_eo_ai");
    step(mk(1,0,0,4'h0,8'h00, C_CO,           8'h00, 4'h1,8'h0E,0,0,0), "hlt_pc_held");
    step(mk(1,0,0,4'h0,8'h00, C_AO,           8'h8E, 4'h1,8'h0E,0,0,0), "hlt_a_held");
    step(mk(1,0,0,4'h0,8'h00, C_EO|C_MI,      8'h05, 4'h1,8'h0E,0,0,0), "mar_from_alu");
    step(mk(1,0,0,4'h0,8'h00, C_RO|C_OI,      8'hAA, 4'h1,8'hAA,0,0,0), "hlt_ram_write");

    // Contention: bus reads zero, error latches and stays until reset.
    step(mk(1,0,0,4'h0,8'h00, C_AO|C_RO|C_BI, 8'h00, 4'h1,8'hAA,0,0,1), "contention");
    step(mk(1,0,0,4'h0,8'h00, 12'h000,        8'h00, 4'h1,8'hAA,0,0,1), "err_sticky");
    step(mk(1,0,0,4'h0,8'h00, C_EO,           8'h8E, 4'h1,8'hAA,0,0,1), "b_loaded_zero");
    step(mk(0,0,0,4'h0,8'h00, 12'h000,        8'h00, 4'h0,8'h00,0,0,0), "err_reset");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
